bcd_conv_arbiter: RTL
=====================

# bcd_conv_arbiter

Sequential binary-to-BCD conversion engine shared between two requesters, such as the memory debug port and the register-file debug port of the pipeline. It arbitrates round-robin between the two requesters and captures the granted operand. It then runs a shift-and-add-3 (double-dabble) conversion over WIDTH cycles and presents packed BCD digits with a one-cycle completion pulse tagged with the requester ID. It replaces per-port combinational decimal conversion with one time-multiplexed unit.

## Interface
- WIDTH, 8: binary operand width.
- DIGITS, 3: number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- req0  in  1  requester 0 conversion request, level.
- bin0  in  WIDTH  requester 0 operand, unsigned.
- req1  in  1  requester 1 conversion request, level.
- bin1  in  WIDTH  requester 1 operand, unsigned.
- gnt0  out  1  one-cycle pulse: requester 0 operand captured.
- gnt1  out  1  one-cycle pulse: requester 1 operand captured.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse: bcd valid.
- done_id  out  1  requester whose result is on bcd (0/1).
- bcd  out  4*DIGITS  packed BCD result, most-significant digit in the top nibble.

## Operation
- FSM states: IDLE → SHIFT → DONE → IDLE.
- IDLE, no req: stay in IDLE.
- IDLE, only one req high: grant that requester.
- IDLE, both reqs high: grant the requester ≠ last_id. last_id resets to 1, so requester 0 wins the first tie.
- Grant edge actions (leaving IDLE):
  - capture the selected bin into the shift register;
  - clear the BCD scratch register;
  - load count = WIDTH;
  - set gnt_x = 1 for the next cycle;
  - record last_id and cur_id;
  - go to SHIFT.
- SHIFT, each edge:
  - every scratch digit ≥ 5 gets +3 (4-bit add, no carry between digits);
  - then {scratch, shift} is shifted left 1, with the shift-register MSB entering scratch bit 0;
  - count decrements.
  - The edge where count goes from 1 to 0 moves to DONE.
- DONE, one cycle: done = 1, done_id = cur_id, and bcd is updated on entry from the final scratch value. Then go to IDLE.
- bcd and done_id are held until the next DONE.
- Requests are only sampled in IDLE. A req seen in SHIFT or DONE waits; it is not lost if it is held.
- Requester rules:
  - hold req until its gnt;
  - keep bin stable while req is high;
  - may drop req before gnt (withdrawal, no effect).
- req still high in the cycle after gnt is treated as a new request.
- No saturation or overflow cases: every WIDTH-bit value fits in DIGITS digits.

## Timing
- Reset (rst_n low, asynchronous):
  - gnt0 = gnt1 = done = busy = 0;
  - done_id = 0, bcd = 0;
  - state = IDLE, last_id = 1, count = 0.
- Reset takes effect immediately, mid-conversion included. The in-flight conversion is discarded and done does not pulse after release.
- Edge E0 samples req in IDLE. gnt is high in cycle C1, which is also the first SHIFT cycle.
- SHIFT occupies WIDTH cycles (C1..C8 for WIDTH = 8). done is high in cycle C(WIDTH+1), i.e. 8 cycles after gnt.
- Back-to-back throughput: one result per WIDTH+2 cycles (IDLE + WIDTH × SHIFT + DONE).
- busy is high from C1 through the DONE cycle inclusive.
- All outputs are registered; there is no combinational path from req or bin to any output.

## Test plan
- Single request: req0 = 1, bin0 = 8'd255 in IDLE → gnt0 pulses next cycle; done 8 cycles after gnt0 with bcd = 12'h255, done_id = 0; gnt1 never asserts.
- Simultaneous tie: req0 = req1 = 1 after reset, bin0 = 8'd0, bin1 = 8'd200 → gnt0 first, done with bcd = 12'h000, id 0; then gnt1, done with bcd = 12'h200, id 1; second done exactly 10 cycles after the first.
- Fairness: both reqs held high continuously for 6 conversions → grants alternate 0,1,0,1,0,1; done_id matches each grant.
- Digit-adjust boundaries: bin1 = 8'd99 → 12'h099; 8'd100 → 12'h100; 8'd59 → 12'h059; 8'd9 → 12'h009; 8'd10 → 12'h010.
- Reset mid-SHIFT: assert rst_n = 0 in the 4th SHIFT cycle → all outputs 0 immediately (before the next edge), no done after release. Then req0 with bin0 = 8'd37 → bcd = 12'h037.
- Late request: req1 rises during the DONE cycle of a requester-0 conversion → not granted in DONE; gnt1 one cycle after the FSM re-enters IDLE; bcd keeps the previous result until the new done.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: one binary-to-BCD (double-dabble) engine shared by two
// requesters under round-robin arbitration.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   req0/bin0      - requester 0 level request and unsigned operand
//   req1/bin1      - requester 1 level request and unsigned operand
//   gnt0/gnt1      - one-cycle pulse: that requester's operand was captured
//   busy           - engine is not idle
//   done           - one-cycle pulse: bcd holds a fresh result
//   done_id        - requester that owns the result on bcd
//   bcd            - packed BCD digits, most-significant digit in top nibble
module bcd_conv_arbiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic [WIDTH-1:0]    bin0,
  input  logic                req1,
  input  logic [WIDTH-1:0]    bin1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                busy,
  output logic                done,
  output logic                done_id,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_id_q, last_id_d;
  logic               cur_id_q, cur_id_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               done_id_q, done_id_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;

  logic               sel;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_shl;

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    cur_id_d  = cur_id_q;
    count_d   = count_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    bcd_d     = bcd_q;
    sel       = 1'b0;

    // Per-digit add-3 correction (no carry between digits), then shift in the
    // operand MSB.
    adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    scratch_shl = {adj[BCD_W-2:0], shift_q[WIDTH-1]};

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win last time goes first.
          sel       = (req0 && req1) ? ~last_id_q : req1;
          shift_d   = sel ? bin1 : bin0;
          scratch_d = '0;
          count_d   = CNT_W'(WIDTH);
          gnt0_d    = ~sel;
          gnt1_d    = sel;
          last_id_d = sel;
          cur_id_d  = sel;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = scratch_shl;
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        count_d   = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = cur_id_q;
          bcd_d     = scratch_shl;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_id_q <= 1'b1;
      cur_id_q  <= 1'b0;
      count_q   <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      cur_id_q  <= cur_id_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      bcd_q     <= bcd_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd     = bcd_q;

endmodule
